// File: rtl/a1csa_seq_ctrl.sv
// a1csa_seq_ctrl: multi-cycle W-bit adder sequencer. Time-multiplexes one
// external 4-bit add-one carry-select slice, one digit per cycle, LSB first,
// and forms the ripple carry from the slice gen/prop outputs.
//
// Optional feature macro: A1CSA_SEQ_OVF_EN (adds registered ovf output).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, cin sampled on accept)
//   out_valid / out_ready result handshake (s, cout registered)
//   slc_a, slc_b, slc_sel slice operand digits and select (carry); 0 outside RUN
//   slc_s, slc_gen, slc_prop  slice sum, generate, propagate
//   ovf                   two's-complement overflow (A1CSA_SEQ_OVF_EN only)
module a1csa_seq_ctrl #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
    output logic         cout,
`ifdef A1CSA_SEQ_OVF_EN
    output logic         ovf,
`endif
    output logic [3:0]   slc_a,
    output logic [3:0]   slc_b,
    output logic         slc_sel,
    input  logic [3:0]   slc_s,
    input  logic         slc_gen,
    input  logic         slc_prop
);

    localparam int unsigned ND = W / 4;
    localparam int unsigned IW = (ND > 1) ? $clog2(ND) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          carry_nxt;
    logic          last_digit;

    // Ripple carry out of the current digit.
    assign carry_nxt  = slc_gen | (slc_prop & carry);
    assign last_digit = (idx == IW'(ND - 1));

    // Slice drive: current digit of each operand, running carry as select.
    always_comb begin
        slc_a   = '0;
        slc_b   = '0;
        slc_sel = 1'b0;
        if (state == RUN) begin
            slc_a   = op_a[{idx, 2'b00} +: 4];
            slc_b   = op_b[{idx, 2'b00} +: 4];
            slc_sel = carry;
        end
    end

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef A1CSA_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b;
                        carry    <= cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    s[{idx, 2'b00} +: 4] <= slc_s;
                    carry                <= carry_nxt;
                    if (last_digit) begin
                        // idx wraps explicitly so non-power-of-two ND also returns to 0.
                        idx       <= '0;
                        cout      <= carry_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef A1CSA_SEQ_OVF_EN
                        ovf       <= (op_a[W-1] == op_b[W-1]) && (slc_s[3] != op_a[W-1]);
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a1csa_seq_ctrl.sv
// Self-checking bench for a1csa_seq_ctrl: behavioural slice model, directed
// cases plus randomized operands with randomized out_ready stalls.
module tb_a1csa_seq_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned ND = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef A1CSA_SEQ_OVF_EN
    logic         ovf;
`endif
    logic [3:0]   slc_a;
    logic [3:0]   slc_b;
    logic         slc_sel;
    logic [3:0]   slc_s;
    logic         slc_gen;
    logic         slc_prop;

    int n_pass = 0;
    int n_fail = 0;
    logic [ND-1:0] sel_log;

    always #5 clk = ~clk;

    a1csa_seq_ctrl #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .cout     (cout),
`ifdef A1CSA_SEQ_OVF_EN
        .ovf      (ovf),
`endif
        .slc_a    (slc_a),
        .slc_b    (slc_b),
        .slc_sel  (slc_sel),
        .slc_s    (slc_s),
        .slc_gen  (slc_gen),
        .slc_prop (slc_prop)
    );

    // External add-one carry-select slice: sum = a+b+sel, gen/prop from a+b.
    logic [4:0] raw;
    always_comb begin
        raw      = {1'b0, slc_a} + {1'b0, slc_b};
        slc_gen  = raw[4];
        slc_prop = (raw[3:0] == 4'hF);
        slc_s    = raw[3:0] + {3'b000, slc_sel};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, RUN (slc_sel logged), optional stall, release.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input int stall);
        int t;
        int lat;
        logic [W:0] exp_sum;
        logic [W-1:0] s_hold;
        logic cout_hold;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("accept_ready", 64'(in_ready), 64'(1));
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0;
        sel_log = '0;
        while (!out_valid && lat < 20) begin
            if (lat < int'(ND)) sel_log[lat] = slc_sel;
            out_ready = 1'($urandom);   // no effect outside DONE
            tick();
            lat++;
        end
        out_ready = 1'b0;
        check("latency", 64'(lat), 64'(ND));
        exp_sum = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        check("sum", 64'(s), 64'(exp_sum[W-1:0]));
        check("cout", 64'(cout), 64'(exp_sum[W]));
`ifdef A1CSA_SEQ_OVF_EN
        check("ovf", 64'(ovf),
              64'((ta[W-1] == tb_[W-1]) && (exp_sum[W-1] != ta[W-1])));
`endif
        s_hold = s;
        cout_hold = cout;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_s", 64'({cout, s}), 64'({cout_hold, s_hold}));
            check("stall_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'(0));
        check("release_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [W-1:0] s_hold;
        logic [W:0]   exp_sum;
        int t;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_s", 64'(s), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_slc", 64'({slc_a, slc_b, slc_sel}), 64'(0));

        // Directed arithmetic
        run_op(16'h1234, 16'h0FFF, 1'b0, 0);
        check("d1_s", 64'(s), 64'(16'h2233));
        run_op(16'hFFFF, 16'h0000, 1'b1, 1);
        check("d2_s", 64'(s), 64'(16'h0000));
        check("d2_cout", 64'(cout), 64'(1));
        check("d2_sel_chain", 64'(sel_log), 64'(4'hF));
        run_op(16'h8000, 16'h8000, 1'b0, 0);
        check("d3_cout", 64'(cout), 64'(1));
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        check("d4_s", 64'(s), 64'(16'h8000));

        // Backpressure with a new request pending
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        check("bp_latency", 64'(t), 64'(ND));
        for (int i = 0; i < 5; i++) begin
            check("bp_s", 64'({cout, s}), 64'({1'b0, 16'h3333}));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_slc_zero", 64'({slc_a, slc_b, slc_sel}), 64'(0));
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle", 64'(in_ready), 64'(1));
        tick();   // in_valid still high: pending operands accepted here
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            tick();
            t++;
        end
        check("bp_next_latency", 64'(t), 64'(ND));
        check("bp_next_sum", 64'({cout, s}), 64'(17'h10000));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset asserted at RUN digit 2
        a = 16'h4321; b = 16'h1234; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_slc_active", 64'({slc_a, slc_b}), 64'({4'h3, 4'h2}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_in_ready", 64'(in_ready), 64'(1));
        check("mid_out_valid", 64'(out_valid), 64'(0));
        check("mid_s", 64'({cout, s}), 64'(0));
        check("mid_slc", 64'({slc_a, slc_b, slc_sel}), 64'(0));
        tick();
        check("mid_stay_idle", 64'(out_valid), 64'(0));
        run_op(16'h0001, 16'h0001, 1'b0, 0);
        check("post_rst_sum", 64'(s), 64'(16'h0002));

        // Randomized operands with randomized stalls
        for (int n = 0; n < 1000; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
        s_hold = s;
        exp_sum = '0;
        if (s_hold === exp_sum[W-1:0]) exp_sum = '0;

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/a1csa_seq_ctrl.md
Name: a1csa_seq_ctrl

Overview:
- Multi-cycle sequencer that performs a W-bit addition by time-multiplexing one external 4-bit add-one carry-select slice, one nibble (digit) per cycle, LSB digit first.
- Drives the slice operands and the slice select input (carry-in).
- Forms the ripple carry from the slice gen/prop outputs and assembles the W-bit sum.
- Sits between a valid/ready operand producer and a valid/ready result consumer.

Parameters:
- W, 16, operand/sum width in bits; must be a multiple of 4 and at least 8.
- ND, W/4, number of digits (derived; not overridden).
- IW, clog2(ND), width of the digit index counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- a  input  W  operand A; sampled on accept.
- b  input  W  operand B; sampled on accept.
- cin  input  1  carry-in; sampled on accept.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- s  output  W  sum; registered.
- cout  output  1  carry out of bit W-1; registered.
- slc_a  output  4  operand A digit to the slice.
- slc_b  output  4  operand B digit to the slice.
- slc_sel  output  1  slice select (running carry).
- slc_s  input  4  slice sum.
- slc_gen  input  1  slice generate (carry of a+b).
- slc_prop  input  1  slice propagate (a+b == 4'hF).

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is synchronous and active-high, and overrides every other input in any state, including mid-RUN. After reset:
  - state=IDLE, idx=0, carry=0
  - s=0, cout=0, out_valid=0, in_ready=1
  - operand registers=0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch a, b, cin into opA/opB/carry, set idx=0, go to RUN.
  - s and cout keep their previous values.
- RUN:
  - Combinationally drive slc_a=opA[4*idx+3:4*idx], slc_b=opB[4*idx+3:4*idx], slc_sel=carry.
  - Each edge: s[4*idx+3:4*idx] <= slc_s; carry <= slc_gen | (slc_prop & carry); idx <= idx+1.
  - When idx==ND-1, the same edge also sets cout <= slc_gen | (slc_prop & carry) and moves to DONE.
  - in_ready=0, and in_valid is ignored.
- DONE:
  - out_valid=1; s and cout are held stable.
  - On out_ready=1: go to IDLE, out_valid falls on the next edge.
  - There is no direct DONE to RUN path, so back-to-back throughput is one operation per ND+2 cycles.
- slc_a, slc_b, slc_sel are 0 outside RUN.
- Latency: with accept at edge k, RUN spans edges k+1..k+ND, and out_valid is high after edge k+ND, i.e. ND cycles after accept.
- Arithmetic: unsigned modulo 2^W. {cout,s} == a+b+cin exactly.
- The slice is treated as combinational; its response is consumed in the same cycle it is driven.
- Boundary cases:
  - All-ones propagate chain (e.g. FFFF+0000+1): carry ripples one digit per cycle; no special case.
  - idx wraps to 0 on entry to DONE.
  - out_ready high while not in DONE has no effect.

Optional Feature:
- Macro: A1CSA_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, registered, reset 0).
  - ovf is updated on the final RUN edge to (opA[W-1]==opB[W-1]) && (slc_s[3]!=opA[W-1]), i.e. two's-complement overflow.
  - ovf is held through DONE with s.
- Undefined: no ovf port and no extra logic; all other behaviour is identical.

Test Plan:
- W=16, a=16'h1234, b=16'h0FFF, cin=0 -> s=16'h2233, cout=0, out_valid exactly 4 cycles after accept.
- a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, cout=1; slc_sel observed 1,1,1,1 across the RUN digits.
- a=16'h8000, b=16'h8000, cin=0 -> s=16'h0000, cout=1; with A1CSA_SEQ_OVF_EN, ovf=1. With a=16'h7FFF, b=16'h0001 -> s=16'h8000, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> s/cout stable, in_ready=0, new operands not captured. Release out_ready -> IDLE, next operation accepted.
- Assert rst for 1 cycle at RUN digit 2 -> next cycle state=IDLE, out_valid=0, s=0, cout=0, slc_* = 0, in_ready=1. A following op a=16'h0001, b=16'h0001 gives s=16'h0002.
- Random 1000 operand triples with randomized out_ready stalls -> {cout,s}==a+b+cin on every handshake.
